// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect/stall control, instruction-memory bus and IF/ID outputs of the fetch stage
interface fetch_stage_if #(parameter int XLEN = 32);
  logic stall;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc_plus4;
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from a wait-state imem and presents one registered instruction per cycle to decode
module fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h13)
) (
  input logic clk,
  input logic reset,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, drain_q, drain_d, skid_pc_q, skid_pc_d, skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
  logic if_valid_q, if_valid_d, req, ack, slot_free;
  assign req = !reset && state_q != HOLD;
  assign ack = bus.imem_ack && req;
  assign slot_free = !if_valid_q || !bus.stall;
  assign bus.imem_req = req;
  // DRAIN keeps the abandoned address on the bus until its ack retires it
  assign bus.imem_addr = state_q == DRAIN ? drain_q : pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_pc = if_pc_q;
  assign bus.if_inst = if_inst_q;
  assign bus.if_pc_plus4 = if_pc_q + XLEN'(4);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drain_d = drain_q;
    skid_pc_d = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_valid_d = if_valid_q;
    if_pc_d = if_pc_q;
    if_inst_d = if_inst_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~XLEN'(3);
      if_valid_d = 1'b0;
      if_inst_d = NOP_INST;
      state_d = (state_q == HOLD || ack) ? FETCH : DRAIN;
      drain_d = state_q == FETCH ? pc_q : drain_q;
    end else if (state_q == FETCH) begin
      if (ack) begin
        pc_d = pc_q + XLEN'(4);
        if (slot_free) begin
          {if_valid_d, if_pc_d, if_inst_d} = {1'b1, pc_q, bus.imem_rdata};
        end else begin
          skid_pc_d = pc_q;
          skid_inst_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end else if (slot_free) begin
        if_valid_d = 1'b0;
      end
    end else if (state_q == HOLD) begin
      if (!bus.stall) begin
        {if_valid_d, if_pc_d, if_inst_d} = {1'b1, skid_pc_q, skid_inst_q};
        state_d = FETCH;
      end
    end else if (ack) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      drain_q <= '0;
      skid_pc_q <= '0;
      skid_inst_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q <= '0;
      if_inst_q <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drain_q <= drain_d;
      skid_pc_q <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_valid_q <= if_valid_d;
      if_pc_q <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end
endmodule
